// File: rtl/tff_counter_ctrl_if.sv
// Command/status bundle between a command source, the t_ff array and tff_counter_ctrl.
// The master side drives commands and the array's Q vector; the slave side is the sequencer.
interface tff_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up_dn;
    logic             one_shot;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] t_out;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, clear, load, load_val, up_dn, one_shot, limit, q_in,
        input  t_out, busy, tc, done
    );

    modport slave (
        input  start, stop, clear, load, load_val, up_dn, one_shot, limit, q_in,
        output t_out, busy, tc, done
    );
endinterface

// File: rtl/tff_counter_ctrl.sv
// Sequencer for a WIDTH-bit counter made of t_ff cells: computes each cell's T input
// from the fed-back Q vector to count up/down modulo (limit+1), load, or clear.
module tff_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset_negative,
    tff_counter_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        LOAD  = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             one_shot_q, one_shot_d;

    logic [WIDTH-1:0] inc_t, dec_t;
    logic             carry_up, borrow_dn;
    logic             wrap, abort;
    logic [WIDTH-1:0] t_out;
    logic             tc, done;

    // Toggle masks: bit i toggles when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        carry_up  = 1'b1;
        borrow_dn = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            inc_t[i]  = carry_up;
            dec_t[i]  = borrow_dn;
            carry_up  = carry_up & bus.q_in[i];
            borrow_dn = borrow_dn & ~bus.q_in[i];
        end
    end

    assign wrap  = dir_q ? (bus.q_in == limit_q) : (bus.q_in == '0);
    assign abort = bus.clear | bus.load | bus.stop;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        limit_d    = limit_q;
        one_shot_d = one_shot_q;
        t_out      = '0;
        tc         = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !abort) begin
                    state_d    = RUN;
                    dir_d      = bus.up_dn;
                    limit_d    = bus.limit;
                    one_shot_d = bus.one_shot;
                end
            end
            RUN: begin
                // Any abort freezes the count in the cycle it is sampled.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    tc = wrap;
                    if (wrap) t_out = dir_q ? bus.q_in : (bus.q_in ^ limit_q);
                    else      t_out = dir_q ? inc_t : dec_t;
                    if (wrap && one_shot_q) state_d = DONE;
                end
            end
            CLEAR: begin
                t_out   = bus.q_in;
                state_d = IDLE;
            end
            LOAD: begin
                t_out   = bus.q_in ^ bus.load_val;
                state_d = IDLE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.clear)     state_d = CLEAR;
        else if (bus.load) state_d = LOAD;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_negative) begin
        if (!reset_negative) begin
            state_q    <= IDLE;
            dir_q      <= 1'b1;
            limit_q    <= '0;
            one_shot_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            limit_q    <= limit_d;
            one_shot_q <= one_shot_d;
        end
    end

    assign bus.t_out = t_out;
    assign bus.tc    = tc;
    assign bus.done  = done;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Bench for tff_counter_ctrl: behavioural t_ff array plus a counter-level reference model,
// directed scenarios followed by randomized command traffic.
module tb_tff_counter_ctrl;
    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    logic clk = 1'b0;
    logic reset_negative;
    int   errors = 0;
    int   checks = 0;

    tff_counter_ctrl_if #(.WIDTH(WIDTH)) bus();

    tff_counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset_negative(reset_negative),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    // The t_ff array: each cell toggles when its T input is high, cleared by the shared reset.
    logic [WIDTH-1:0] q;
    always @(posedge clk or negedge reset_negative) begin
        if (!reset_negative) q <= '0;
        else                 q <= q ^ bus.t_out;
    end
    assign bus.q_in = q;

    // Reference model: counter value plus which activity is pending.
    int m_q;
    bit m_run, m_clr, m_ld, m_done;
    bit m_dir, m_os;
    int m_lim;

    task automatic model_reset();
        m_q = 0; m_run = 0; m_clr = 0; m_ld = 0; m_done = 0;
        m_dir = 1; m_os = 0; m_lim = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmd(input bit st, input bit sp, input bit cl, input bit ld, input int lv,
                       input bit ud, input bit os, input int lim);
        bus.start    = st;
        bus.stop     = sp;
        bus.clear    = cl;
        bus.load     = ld;
        bus.load_val = lv[WIDTH-1:0];
        bus.up_dn    = ud;
        bus.one_shot = os;
        bus.limit    = lim[WIDTH-1:0];
    endtask

    task automatic idle_in();
        cmd(0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        int nq;
        bit e_tc, e_done, e_busy, wrap, abort, idle;
        @(negedge clk);
        abort  = bus.clear || bus.load || bus.stop;
        e_busy = m_run || m_clr || m_ld || m_done;
        idle   = !e_busy;
        nq     = m_q;
        e_tc   = 0;
        e_done = 0;
        if (m_run && !abort) begin
            wrap = m_dir ? (m_q == m_lim) : (m_q == 0);
            e_tc = wrap;
            if (m_dir) nq = wrap ? 0 : (m_q + 1) % MOD;
            else       nq = wrap ? m_lim : m_q - 1;
        end else if (m_clr) begin
            nq = 0;
        end else if (m_ld) begin
            nq = int'(bus.load_val);
        end else if (m_done) begin
            e_done = 1;
        end
        check("q",     q,          m_q);
        check("t_out", bus.t_out,  m_q ^ nq);
        check("busy",  bus.busy,   e_busy);
        check("tc",    bus.tc,     e_tc);
        check("done",  bus.done,   e_done);
        @(posedge clk);
        if (bus.clear) begin
            m_run = 0; m_clr = 1; m_ld = 0; m_done = 0;
        end else if (bus.load) begin
            m_run = 0; m_clr = 0; m_ld = 1; m_done = 0;
        end else if (m_run) begin
            m_clr = 0; m_ld = 0;
            m_done = !bus.stop && e_tc && m_os;
            m_run  = !bus.stop && !(e_tc && m_os);
        end else begin
            m_clr = 0; m_ld = 0; m_done = 0;
            m_run = idle && bus.start && !bus.stop;
            if (m_run) begin
                m_dir = bus.up_dn;
                m_lim = int'(bus.limit);
                m_os  = bus.one_shot;
            end
        end
        m_q = nq;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        idle_in();
        repeat (n) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q"},     q,         0);
        check({tag, "_t_out"}, bus.t_out, 0);
        check({tag, "_busy"},  bus.busy,  0);
        check({tag, "_tc"},    bus.tc,    0);
        check({tag, "_done"},  bus.done,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_in();
        model_reset();
        reset_negative = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) reset_negative = 1'b1;
        @(posedge clk);
        #1;

        // Free-running up count, limit 9: two full periods.
        cmd(1, 0, 0, 0, 0, 1, 0, 9); cycle();
        idle_cycles(22);
        cmd(0, 1, 0, 0, 0, 1, 0, 0); cycle();
        idle_cycles(1);

        // Reset asserted mid-run at q=5.
        cmd(0, 0, 1, 0, 0, 1, 0, 0); cycle();
        idle_cycles(1);
        cmd(1, 0, 0, 0, 0, 1, 0, 9); cycle();
        idle_cycles(5);
        check("t1_q_before_reset", q, 5);
        #2 reset_negative = 1'b0;
        #1;
        check_all_zero("t1_reset_mid_run");
        model_reset();
        @(negedge clk) reset_negative = 1'b1;
        @(posedge clk);
        #1;

        // One-shot down count from 2 with reload 5.
        cmd(0, 0, 0, 1, 2, 1, 0, 0); cycle();
        idle_cycles(1);
        cmd(1, 0, 0, 0, 0, 0, 1, 5); cycle();
        idle_cycles(6);
        check("t3_final_q", q, 5);
        check("t3_idle", bus.busy, 0);

        // Up count starting above the limit passes through 15 -> 0 without tc.
        cmd(0, 0, 0, 1, 12, 1, 0, 0); cycle();
        idle_cycles(1);
        cmd(1, 0, 0, 0, 0, 1, 0, 9); cycle();
        idle_cycles(16);

        // Clear and stop together during a run: clear wins.
        cmd(0, 0, 1, 0, 0, 1, 0, 0); cycle();
        idle_cycles(1);
        cmd(1, 0, 0, 0, 0, 1, 0, 9); cycle();
        idle_cycles(6);
        check("t5_q_at_6", q, 6);
        cmd(0, 1, 1, 0, 0, 1, 0, 0); cycle();
        idle_cycles(2);
        check("t5_cleared", q, 0);
        check("t5_idle", bus.busy, 0);

        // Stop freezes the count; then a limit-0 run holds at 0 with tc every cycle.
        cmd(1, 0, 0, 0, 0, 1, 0, 9); cycle();
        idle_cycles(3);
        cmd(0, 1, 0, 0, 0, 1, 0, 0); cycle();
        idle_cycles(2);
        check("t6_frozen", q, 3);
        cmd(0, 0, 1, 0, 0, 1, 0, 0); cycle();
        idle_cycles(1);
        cmd(1, 0, 0, 0, 0, 1, 0, 0); cycle();
        idle_cycles(4);
        cmd(0, 1, 0, 0, 0, 1, 0, 0); cycle();

        // Randomized command traffic.
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            cmd(r >= 8 && r < 40, r >= 4 && r < 12 && r != 7, r < 3, r >= 3 && r < 7,
                $urandom_range(0, MOD - 1), $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MOD - 1));
            cycle();
        end
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
